// File: rtl/if_id_queue_pkg.sv
// if_id_queue_pkg
// Shared widths, constants and helpers for the IF/ID instruction queue.
//   INST_W / INST_ADDR_W / INT_W / HOLD_FLAG_W : bus widths
//   INST_NOP  : instruction presented to decode when nothing is queued
//   ZERO_WORD : address presented when nothing is queued
//   INT_NONE  : interrupt flag value meaning "no interrupt"
//   HOLD_IF   : hold level at or above which the IF/ID stage is held
package if_id_queue_pkg;

    localparam int INST_W      = 32;
    localparam int INST_ADDR_W = 32;
    localparam int INT_W       = 8;
    localparam int HOLD_FLAG_W = 3;

    localparam logic [INST_W-1:0]      INST_NOP  = 32'h0000_0013;
    localparam logic [INST_ADDR_W-1:0] ZERO_WORD = 32'h0000_0000;
    localparam logic [INT_W-1:0]       INT_NONE  = 8'h00;
    localparam logic [HOLD_FLAG_W-1:0] HOLD_IF   = 3'd1;

    function automatic logic is_held(input logic [HOLD_FLAG_W-1:0] flag,
                                     input logic [HOLD_FLAG_W-1:0] level);
        return flag >= level;
    endfunction

endpackage

// File: rtl/if_id_queue_if.sv
// if_id_queue_if
// Bundles the fetch-side push channel, pipeline control and decode-side
// head outputs of the IF/ID queue.
//   slave  : the queue itself (consumes inst_*_i/hold/flush/int_flag_i,
//            drives ready, head outputs, int_flag_o and count_o)
//   master : the surrounding pipeline (the opposite directions)
interface if_id_queue_if
    import if_id_queue_pkg::*;
#(
    parameter int DW    = INST_W,
    parameter int AW    = INST_ADDR_W,
    parameter int IW    = INT_W,
    parameter int DEPTH = 4
);
    logic [DW-1:0]              inst_i;
    logic [AW-1:0]              inst_addr_i;
    logic                       inst_valid_i;
    logic                       inst_ready_o;
    logic [HOLD_FLAG_W-1:0]     hold_flag_i;
    logic                       flush_i;
    logic [IW-1:0]              int_flag_i;
    logic [DW-1:0]              inst_o;
    logic [AW-1:0]              inst_addr_o;
    logic                       inst_valid_o;
    logic [IW-1:0]              int_flag_o;
    logic [$clog2(DEPTH):0]     count_o;

    modport slave (
        input  inst_i, inst_addr_i, inst_valid_i, hold_flag_i, flush_i, int_flag_i,
        output inst_ready_o, inst_o, inst_addr_o, inst_valid_o, int_flag_o, count_o
    );

    modport master (
        output inst_i, inst_addr_i, inst_valid_i, hold_flag_i, flush_i, int_flag_i,
        input  inst_ready_o, inst_o, inst_addr_o, inst_valid_o, int_flag_o, count_o
    );

endinterface

// File: rtl/if_id_queue_ptr.sv
// if_id_queue_ptr
// Read/write pointers and occupancy count for the IF/ID queue.
//   clk, rst      : clock, asynchronous active-low reset
//   push, pop     : advance write / read pointer this edge
//   flush         : return to empty (overrides push and pop)
//   rd_ptr/wr_ptr : head / next-free slot, wrapping modulo DEPTH
//   count         : occupancy 0..DEPTH
//   full, empty   : decoded from count
module if_id_queue_ptr #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    output logic [$clog2(DEPTH)-1:0] rd_ptr,
    output logic [$clog2(DEPTH)-1:0] wr_ptr,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [PW-1:0] PTR_ONE = PW'(1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            // Simultaneous push and pop leaves occupancy unchanged.
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/if_id_queue.sv
// if_id_queue
// DEPTH-entry instruction queue between fetch and decode, replacing the
// single IF/ID register. Fetch may run ahead while decode is held.
//   clk  : clock
//   rst  : asynchronous active-low reset
//   bus  : if_id_queue_if.slave -- push channel (inst_i, inst_addr_i,
//          inst_valid_i, inst_ready_o), control (hold_flag_i, flush_i),
//          interrupt flag (int_flag_i -> int_flag_o), head outputs
//          (inst_o, inst_addr_o, inst_valid_o) and occupancy (count_o)
module if_id_queue
    import if_id_queue_pkg::*;
#(
    parameter int                     DW         = INST_W,
    parameter int                     AW         = INST_ADDR_W,
    parameter int                     IW         = INT_W,
    parameter int                     DEPTH      = 4,
    parameter logic [HOLD_FLAG_W-1:0] HOLD_LEVEL = HOLD_IF,
    parameter logic [DW-1:0]          NOP        = DW'(INST_NOP)
) (
    input  logic              clk,
    input  logic              rst,
    if_id_queue_if.slave      bus
);
    localparam int PW = $clog2(DEPTH);

    logic          hold;
    logic          push;
    logic          pop;
    logic          full;
    logic          empty;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [PW:0]   count;
    logic [IW-1:0] int_flag_q;

    logic [DW-1:0] mem_inst [DEPTH];
    logic [AW-1:0] mem_addr [DEPTH];

    assign hold = is_held(bus.hold_flag_i, HOLD_LEVEL);

    // Ready depends only on the registered count, so a full queue refuses a
    // push even in a cycle where it also pops; this keeps hold/pop out of
    // the ready path back to fetch.
    assign bus.inst_ready_o = ~full;
    assign push = bus.inst_valid_i & ~full & ~bus.flush_i;
    assign pop  = ~empty & ~hold & ~bus.flush_i;

    if_id_queue_ptr #(
        .DEPTH (DEPTH)
    ) u_ptr (
        .clk    (clk),
        .rst    (rst),
        .push   (push),
        .pop    (pop),
        .flush  (bus.flush_i),
        .rd_ptr (rd_ptr),
        .wr_ptr (wr_ptr),
        .count  (count),
        .full   (full),
        .empty  (empty)
    );

    // Storage carries no reset: only count/pointers decide what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_inst[wr_ptr] <= bus.inst_i;
            mem_addr[wr_ptr] <= bus.inst_addr_i;
        end
    end

    // Interrupt flag keeps single-register semantics: not queued, frozen by
    // hold, untouched by flush.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            int_flag_q <= IW'(INT_NONE);
        end else if (!hold) begin
            int_flag_q <= bus.int_flag_i;
        end
    end

    assign bus.inst_o       = empty ? NOP : mem_inst[rd_ptr];
    assign bus.inst_addr_o  = empty ? AW'(ZERO_WORD) : mem_addr[rd_ptr];
    assign bus.inst_valid_o = ~empty;
    assign bus.int_flag_o   = int_flag_q;
    assign bus.count_o      = count;

endmodule

// File: doc/if_id_queue.md
Name: if_id_queue

Overview:
- Parametrised successor to the single-entry IF/ID pipeline register.
- Replaces one flop stage with a DEPTH-entry instruction queue between fetch and decode.
- Lets fetch run ahead while decode is held. Adds ready backpressure, flush, occupancy reporting and explicit output valid.
- The interrupt flag keeps single-register semantics alongside the queue.

Parameters:
- DW, 32, instruction width
- AW, 32, instruction address width
- IW, 8, interrupt flag width
- DEPTH, 4, queue entries; power of two, >=2
- HOLD_LEVEL, 1, hold_flag_i value at or above which the IF/ID stage is held (matches `Hold_If)
- NOP, 32'h00000013, instruction driven when empty (`INST_NOP)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- inst_i  in  DW  fetched instruction
- inst_addr_i  in  AW  address of inst_i
- inst_valid_i  in  1  inst_i/inst_addr_i valid this cycle
- inst_ready_o  out  1  queue can accept a push this cycle
- hold_flag_i  in  3  pipeline hold level
- flush_i  in  1  discard all queued entries (jump/trap)
- int_flag_i  in  IW  interrupt flag from fetch side
- inst_o  out  DW  head instruction to decode
- inst_addr_o  out  AW  head address
- inst_valid_o  out  1  head entry valid
- int_flag_o  out  IW  registered interrupt flag
- count_o  out  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Reset (rst=0, async):
  - count=0; read/write pointers=0.
  - inst_o=NOP, inst_addr_o=0, inst_valid_o=0, int_flag_o=0 (`INT_NONE).
  - inst_ready_o=1 once reset deasserts.
- Signal definitions:
  - hold = (hold_flag_i >= HOLD_LEVEL).
  - push = inst_valid_i & inst_ready_o & ~flush_i.
  - pop = inst_valid_o & ~hold & ~flush_i.
- Ready and full/empty:
  - inst_ready_o = (count != DEPTH). Purely from registered count; no combinational path from hold or pop.
  - A full queue therefore refuses a push even in a cycle where it pops.
- Output path:
  - inst_o/inst_addr_o/inst_valid_o decode the head entry combinationally from registered storage.
  - When count==0: inst_o=NOP, inst_addr_o=0, inst_valid_o=0.
- Latency: an entry pushed at edge N is visible on the outputs after edge N. This is one cycle, equal to the old register when the queue is empty.
- Pointers and count:
  - Wrap modulo DEPTH using pointer width $clog2(DEPTH).
  - count updates +1 (push only), -1 (pop only), unchanged (both or neither).
- Simultaneous push and pop while not full: both occur; count unchanged; FIFO order preserved.
- Push while empty and held: entry stored; inst_valid_o=1 next cycle; head stays until hold drops.
- Hold:
  - Head entry and int_flag_o frozen.
  - Pushes continue until full.
  - Hold never drops or duplicates an entry.
- Flush:
  - Takes effect at the next edge: count=0, pointers reset.
  - Outputs become NOP/0/invalid after the edge.
  - Flush overrides push and pop in the same cycle; the incoming instruction is dropped.
  - Storage contents are not cleared (don't-care).
- Interrupt flag:
  - int_flag_o <= int_flag_i each edge unless hold.
  - Flush does not clear it.
  - Not queued with instructions.
- inst_valid_i=0: no push. Storage unchanged; no NOP is written into the queue.

Decomposition:
- The shared defines file supplies `INST_NOP`, `ZeroWord`, `INT_NONE`, `INT_BUS`, `Hold_Flag_Bus`, `Hold_If`, `InstBus` and `InstAddrBus`. Parameter defaults take their values from these.
- One natural sub-module: `if_id_queue_ptr`. It holds read/write pointers and count, with inputs push, pop and flush, and outputs rd_ptr, wr_ptr, count, full and empty.
- The int_flag register reuses the existing `gen_pipe_dff` with hold_en=hold.

Test Plan:
- Reset: assert rst=0 mid-operation with 3 entries queued -> same cycle inst_valid_o=0, inst_o=32'h00000013, count_o=0; after release inst_ready_o=1.
- Streaming: push 0x00500093@0x0 then 0x00100113@0x4, hold_flag_i=0 -> decode sees each one cycle after push, in order; count_o stays ≤1.
- Fill under hold: hold_flag_i=1, push 5 instructions (DEPTH=4) -> inst_ready_o=0 after the 4th; the 5th is not accepted and count_o=4. Release hold -> heads drain in order 1..4 over 4 cycles; inst_ready_o=1 after the first pop.
- Flush with push: count_o=2 and flush_i=1 together with inst_valid_i=1 -> after the edge count_o=0, inst_valid_o=0; the pushed instruction never appears.
- Wrap-around: 10 push/pop pairs at steady state (count 1) -> pointers wrap past DEPTH; addresses 0x0..0x24 emerge exactly once each, in order.
- Interrupt flag: int_flag_i=8'h01 with hold_flag_i=1 -> int_flag_o unchanged. After hold drops -> int_flag_o=8'h01 next cycle. A later flush leaves int_flag_o=8'h01.
